nn_banked_weight_mem: RTL and testbench

//  Multi-bank weight/activation store for generated NN layers. Loaded by a

---
 rtl/nn_mem_pkg.sv | 11 +
 rtl/nn_banked_weight_mem_if.sv | 38 +++
 rtl/nn_mem_bank.sv | 40 ++++
 rtl/nn_banked_weight_mem.sv | 129 ++++++++++++
 tb/tb_nn_banked_weight_mem.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/nn_mem_pkg.sv
// Shared types and helpers for the banked weight memory.
package nn_mem_pkg;

  typedef enum logic {ST_CLEAR, ST_RUN} mem_state_t;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_banked_weight_mem_if.sv
// Load stream, parallel read port and status of the banked weight memory.
interface nn_banked_weight_mem_if
  import nn_mem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int BANKS = 4
);
  localparam int AW = clog2_min1(DEPTH);

  // Handshake: a load beat transfers on any rising edge where ld_valid and
  // ld_ready are both high; ld_data/ld_last are only meaningful while
  // ld_valid=1. A read has no back-pressure: rd_en is taken in RUN, and
  // rd_valid pulses for exactly one cycle on the following cycle.
  logic                   ld_valid;
  logic                   ld_ready;
  logic [WIDTH-1:0]       ld_data;
  logic                   ld_last;
  logic                   ld_done;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic [BANKS*WIDTH-1:0] rd_data;
  logic                   rd_valid;
  logic                   busy;
  logic                   err_ovf;
  mem_state_t             state;

  modport master (
    output ld_valid, ld_data, ld_last, rd_en, rd_addr,
    input  ld_ready, ld_done, rd_data, rd_valid, busy, err_ovf, state
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, rd_en, rd_addr,
    output ld_ready, ld_done, rd_data, rd_valid, busy, err_ovf, state
  );

endinterface

// File: rtl/nn_mem_bank.sv
// One bank: synchronous write, registered read-first read port.
module nn_mem_bank
  import nn_mem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [clog2_min1(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           re,
  input  logic [clog2_min1(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]               rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array kept free of reset so it maps onto RAM; clearing is done by the top.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Separate process sees the pre-write array: same-row collisions read old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      if (int'(raddr) < DEPTH) begin
        rdata <= mem[raddr];
      end else begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: rtl/nn_banked_weight_mem.sv
// Multi-bank weight store: sequential load stream in, BANKS words per read out.
module nn_banked_weight_mem
  import nn_mem_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 64,
  parameter int BANKS          = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic                  clk,
  input logic                  rst,
  nn_banked_weight_mem_if.slave bus
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int BW = clog2_min1(BANKS);
  localparam logic [AW-1:0] ROW_LAST  = AW'(DEPTH - 1);
  localparam logic [BW-1:0] BANK_LAST = BW'(BANKS - 1);
  localparam mem_state_t    ST_RESET  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  mem_state_t       state, state_nxt;
  logic [AW-1:0]    clear_ptr;
  logic [BW-1:0]    bank_sel;
  logic [AW-1:0]    waddr;
  logic             clearing;
  logic             accept;
  logic             rd_accept;
  logic             ld_done_q;
  logic             err_ovf_q;
  logic             rd_valid_q;
  logic [AW-1:0]    bank_waddr;
  logic [WIDTH-1:0] bank_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clear_ptr == ROW_LAST) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  assign clearing  = (state == ST_CLEAR);
  assign accept    = bus.ld_valid & bus.ld_ready;
  assign rd_accept = bus.rd_en & (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      clear_ptr <= '0;
    end else if (clearing) begin
      clear_ptr <= (clear_ptr == ROW_LAST) ? '0 : clear_ptr + AW'(1);
    end
  end

  // Write pointer walks banks first, then rows; ld_last always rewinds.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel  <= '0;
      waddr     <= '0;
      err_ovf_q <= 1'b0;
      ld_done_q <= 1'b0;
    end else begin
      ld_done_q <= accept & bus.ld_last;
      if (accept) begin
        if (bus.ld_last) begin
          bank_sel <= '0;
          waddr    <= '0;
        end else if (bank_sel == BANK_LAST) begin
          bank_sel <= '0;
          if (waddr == ROW_LAST) begin
            waddr     <= '0;
            err_ovf_q <= 1'b1;
          end else begin
            waddr <= waddr + AW'(1);
          end
        end else begin
          bank_sel <= bank_sel + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
    end
  end

  assign bank_waddr = clearing ? clear_ptr : waddr;
  assign bank_wdata = clearing ? '0 : bus.ld_data;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic bank_we;
    assign bank_we = clearing | (accept & (bank_sel == BW'(b)));

    nn_mem_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .re    (rd_accept),
      .raddr (bus.rd_addr),
      .rdata (bus.rd_data[b*WIDTH +: WIDTH])
    );
  end

  // Ready is held low during reset even when reset lands directly in RUN.
  assign bus.ld_ready = (state == ST_RUN) & ~rst;
  assign bus.ld_done  = ld_done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = clearing;
  assign bus.err_ovf  = err_ovf_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_nn_banked_weight_mem.sv
// Randomized bench for nn_banked_weight_mem against a flat slot-array model.
module tb_nn_banked_weight_mem;
  import nn_mem_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int BANKS = 4;
  localparam int AW    = clog2_min1(DEPTH);
  localparam int SLOTS = BANKS * DEPTH;
  localparam int RW    = BANKS * WIDTH;

  logic clk;
  logic rst;

  nn_banked_weight_mem_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANKS(BANKS)) bus_if ();

  nn_banked_weight_mem #(
    .WIDTH          (WIDTH),
    .DEPTH          (DEPTH),
    .BANKS          (BANKS),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Model: beat slot k holds the k-th word loaded since the last rewind.
  logic [WIDTH-1:0] ref_mem [SLOTS];
  int               ref_k;
  bit               ref_err;
  logic [RW-1:0]    ref_last_rd;
  logic [RW-1:0]    exp_q [$];
  int               n_checks;
  int               n_errors;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] ref_row(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int b = 0; b < BANKS; b++) v[b*WIDTH +: WIDTH] = ref_mem[r*BANKS + b];
    return v;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < SLOTS; i++) ref_mem[i] = '0;
    ref_k       = 0;
    ref_err     = 1'b0;
    ref_last_rd = '0;
    exp_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: optional load beat and optional read, then all outputs checked.
  task automatic cycle(input bit do_ld, input logic [WIDTH-1:0] d, input bit last,
                       input bit do_rd, input int a);
    bit exp_done;
    bus_if.ld_valid = do_ld;
    bus_if.ld_data  = d;
    bus_if.ld_last  = last;
    bus_if.rd_en    = do_rd;
    bus_if.rd_addr  = AW'(a);
    if (do_ld) check("ld_ready", 64'(bus_if.ld_ready), 64'(1));
    if (do_rd) exp_q.push_back(ref_row(a));
    step();
    bus_if.ld_valid = 1'b0;
    bus_if.ld_last  = 1'b0;
    bus_if.rd_en    = 1'b0;
    exp_done = 1'b0;
    if (do_ld) begin
      ref_mem[ref_k] = d;
      exp_done = last;
      if (ref_k == SLOTS - 1 && !last) ref_err = 1'b1;
      ref_k = last ? 0 : (ref_k + 1) % SLOTS;
    end
    check("ld_done", 64'(bus_if.ld_done), 64'(exp_done));
    check("err_ovf", 64'(bus_if.err_ovf), 64'(ref_err));
    check("rd_valid", 64'(bus_if.rd_valid), 64'(do_rd));
    if (do_rd && exp_q.size() > 0) ref_last_rd = exp_q.pop_front();
    check("rd_data", 64'(bus_if.rd_data), 64'(ref_last_rd));
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 0);
  endtask

  // Clear phase: loads and reads are offered every cycle and must be ignored.
  task automatic wait_clear();
    int n;
    bit bad;
    n   = 0;
    bad = 1'b0;
    while (bus_if.busy && n < 200) begin
      if (bus_if.ld_ready || bus_if.rd_valid) bad = 1'b1;
      bus_if.ld_valid = 1'b1;
      bus_if.ld_data  = WIDTH'($urandom);
      bus_if.rd_en    = 1'b1;
      bus_if.rd_addr  = AW'($urandom_range(0, DEPTH - 1));
      step();
      n++;
    end
    bus_if.ld_valid = 1'b0;
    bus_if.rd_en    = 1'b0;
    check("clear_cycles", 64'(n), 64'(DEPTH));
    check("clear_quiet", 64'(bad), 64'(0));
    check("clear_rd_valid", 64'(bus_if.rd_valid), 64'(0));
    check("run_state", 64'(bus_if.state), 64'(ST_RUN));
  endtask

  task automatic do_reset(input int ncyc);
    rst             = 1'b1;
    bus_if.ld_valid = 1'b0;
    bus_if.ld_last  = 1'b0;
    bus_if.rd_en    = 1'b0;
    repeat (ncyc) step();
    ref_reset();
    check("rst_ld_ready", 64'(bus_if.ld_ready), 64'(0));
    check("rst_ld_done", 64'(bus_if.ld_done), 64'(0));
    check("rst_rd_valid", 64'(bus_if.rd_valid), 64'(0));
    check("rst_rd_data", 64'(bus_if.rd_data), 64'(0));
    check("rst_err_ovf", 64'(bus_if.err_ovf), 64'(0));
    check("rst_busy", 64'(bus_if.busy), 64'(1));
    rst = 1'b0;
    wait_clear();
  endtask

  task automatic load_ramp(input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) idle();
      cycle(1'b1, WIDTH'(8'h10 + i), i == 7, 1'b0, 0);
    end
    idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len;
    rst             = 1'b1;
    bus_if.ld_valid = 1'b0;
    bus_if.ld_data  = '0;
    bus_if.ld_last  = 1'b0;
    bus_if.rd_en    = 1'b0;
    bus_if.rd_addr  = '0;
    n_checks        = 0;
    n_errors        = 0;
    ref_reset();

    // Reset, clear duration, zeroed read with single-cycle rd_valid.
    do_reset(2);
    cycle(1'b0, '0, 1'b0, 1'b1, 5);
    check("clr_row5_zero", 64'(ref_last_rd), 64'(0));
    idle();

    // Ramp load, ld_done once, parallel row readback.
    load_ramp(1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 0);
    check("row0_const", 64'(bus_if.rd_data), 64'(32'h13121110));
    cycle(1'b0, '0, 1'b0, 1'b1, 1);
    check("row1_const", 64'(bus_if.rd_data), 64'(32'h17161514));

    // Same ramp with random gaps after a fresh reset.
    do_reset(1);
    load_ramp(1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1, 0);
    check("gap_row0_const", 64'(bus_if.rd_data), 64'(32'h13121110));
    cycle(1'b0, '0, 1'b0, 1'b1, 1);
    check("gap_row1_const", 64'(bus_if.rd_data), 64'(32'h17161514));

    // Same-cycle read and write of row 0: old data first, new data after.
    cycle(1'b1, 8'hAA, 1'b0, 1'b1, 0);
    check("collide_old", 64'(bus_if.rd_data[7:0]), 64'(8'h10));
    cycle(1'b0, '0, 1'b0, 1'b1, 0);
    check("collide_new", 64'(bus_if.rd_data[7:0]), 64'(8'hAA));

    // Rewind, then 257 beats with no ld_last: overflow after beat 256.
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 0);
    for (int i = 1; i <= SLOTS + 1; i++) begin
      cycle(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 0);
      if (i == SLOTS - 1) check("ovf_before", 64'(bus_if.err_ovf), 64'(0));
      if (i == SLOTS)     check("ovf_after", 64'(bus_if.err_ovf), 64'(1));
    end
    cycle(1'b0, '0, 1'b0, 1'b1, 0);
    check("ovf_beat257", 64'(bus_if.rd_data[7:0]), 64'(ref_mem[0]));

    // Reset mid-load: everything clears, next beat lands in bank0 row0.
    cycle(1'b1, 8'h01, 1'b0, 1'b0, 0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0, 0);
    cycle(1'b1, 8'h03, 1'b0, 1'b0, 0);
    do_reset(1);
    cycle(1'b1, 8'h5C, 1'b0, 1'b0, 0);
    for (int r = 0; r < DEPTH; r++) cycle(1'b0, '0, 1'b0, 1'b1, r);
    cycle(1'b0, '0, 1'b0, 1'b1, 0);
    check("post_rst_row0", 64'(bus_if.rd_data), 64'(32'h0000005C));

    // Random loads with gaps, random ld_last and interleaved reads.
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 300);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2))
          cycle(1'b0, '0, 1'b0, $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1));
        cycle(1'b1, WIDTH'($urandom), (i == len - 1) && ($urandom_range(0, 1) == 1),
              $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1));
      end
      for (int j = 0; j < 16; j++)
        cycle(1'b0, '0, 1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, DEPTH - 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
